// File: rtl/reg_to_apb_pkg.sv
// Shared types for the REG_BUS to APB3 bridge.
package reg_to_apb_pkg;

    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/reg_to_apb_if.sv
// REG_BUS request/response and APB3 master signals of the bridge, bundled.
interface reg_to_apb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    reg_valid_i;
    logic                    reg_write_i;
    logic [ADDR_WIDTH-1:0]   reg_addr_i;
    logic [DATA_WIDTH-1:0]   reg_wdata_i;
    logic [DATA_WIDTH/8-1:0] reg_wstrb_i;
    logic                    reg_ready_o;
    logic [DATA_WIDTH-1:0]   reg_rdata_o;
    logic                    reg_error_o;
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic                    pwrite_o;
    logic                    psel_o;
    logic                    penable_o;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pready_i;
    logic                    pslverr_i;

    // The bridge itself: APB master, REG_BUS responder.
    modport master (
        input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
        output reg_ready_o, reg_rdata_o, reg_error_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        input  prdata_i, pready_i, pslverr_i
    );

    // The surroundings: register initiator plus APB slave.
    modport slave (
        output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
        input  reg_ready_o, reg_rdata_o, reg_error_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
        output prdata_i, pready_i, pslverr_i
    );

endinterface

// File: rtl/reg_to_apb.sv
// REG_BUS to APB3 master bridge: one outstanding request, registered response,
// bounded ACCESS wait with error response on timeout.
module reg_to_apb
    import reg_to_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    reg_to_apb_if.master bus
);

    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic                  error_q;
    logic [CNT_W-1:0]      wait_cnt_q;
    logic                  strb_full;
    logic                  timeout_hit;

    always_comb begin
        strb_full   = &bus.reg_wstrb_i;
        // wait_cnt_q counts earlier stalled ACCESS cycles, so the current one is the last allowed
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            error_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_cnt_q <= '0;
                    if (bus.reg_valid_i) begin
                        if (!bus.reg_write_i || strb_full) begin
                            addr_q  <= bus.reg_addr_i;
                            wdata_q <= bus.reg_wdata_i;
                            write_q <= bus.reg_write_i;
                            state_q <= SETUP;
                        end else begin
                            rdata_q <= '0;
                            error_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                SETUP: state_q <= ACCESS;
                ACCESS: begin
                    if (bus.pready_i) begin
                        rdata_q <= write_q ? '0 : bus.prdata_i;
                        error_q <= bus.pslverr_i;
                        state_q <= RESP;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        error_q <= 1'b1;
                        state_q <= RESP;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    rdata_q <= '0;
                    error_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are gated by state so that reset clears them without waiting for an edge.
    always_comb begin
        bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
        bus.penable_o   = (state_q == ACCESS);
        bus.paddr_o     = bus.psel_o ? addr_q  : '0;
        bus.pwdata_o    = bus.psel_o ? wdata_q : '0;
        bus.pwrite_o    = bus.psel_o ? write_q : 1'b0;
        bus.reg_ready_o = (state_q == RESP);
        bus.reg_rdata_o = bus.reg_ready_o ? rdata_q : '0;
        bus.reg_error_o = bus.reg_ready_o ? error_q : 1'b0;
    end

endmodule

// File: tb/tb_reg_to_apb.sv
// Self-checking bench for reg_to_apb: directed plan scenarios plus randomized
// transactions checked against a latency/response model of the bridge.
module tb_reg_to_apb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_to_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_to_apb #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic idle_inputs;
        bus.reg_valid_i = 1'b0;
        bus.reg_write_i = 1'b0;
        bus.reg_addr_i  = '0;
        bus.reg_wdata_i = '0;
        bus.reg_wstrb_i = '0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
    endtask

    // Issue one request at #1 after an edge and follow it to completion.
    // waits = stalled ACCESS cycles before pready; waits >= TO never answers.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                           input logic [31:0] rd, input logic se, input logic drop_valid);
        bit          strb_err = wr && (strb != 4'hF);
        bit          tmo      = !strb_err && (waits >= int'(TO));
        int          exp_lat  = strb_err ? 1 : (tmo ? 2 + int'(TO) : 3 + waits);
        logic        exp_err  = (strb_err || tmo) ? 1'b1 : se;
        logic [31:0] exp_rd   = (strb_err || tmo || wr) ? 32'h0 : rd;
        int          exp_acc  = strb_err ? 0 : (tmo ? int'(TO) : waits + 1);
        int          c = 0;
        int          acc = 0;
        bit          done = 0;
        bit          stable_ok = 1;
        bit          phase_ok = 1;
        logic [31:0] got_rd = '0;
        logic        got_err = 1'b0;

        bus.reg_valid_i = 1'b1;
        bus.reg_write_i = wr;
        bus.reg_addr_i  = addr;
        bus.reg_wdata_i = wdata;
        bus.reg_wstrb_i = strb;
        while (!done && c < 60) begin
            @(posedge clk);
            #1;
            c++;
            if (drop_valid) bus.reg_valid_i = 1'b0;
            if (bus.psel_o === 1'b1 &&
                (bus.paddr_o !== addr || bus.pwdata_o !== wdata || bus.pwrite_o !== wr))
                stable_ok = 0;
            if (strb_err && bus.psel_o !== 1'b0) phase_ok = 0;
            if (!strb_err && c == 1 && !(bus.psel_o === 1'b1 && bus.penable_o === 1'b0)) phase_ok = 0;
            if (!strb_err && c == 2 && !(bus.psel_o === 1'b1 && bus.penable_o === 1'b1)) phase_ok = 0;
            if (bus.reg_ready_o === 1'b1) begin
                done = 1;
                got_rd = bus.reg_rdata_o;
                got_err = bus.reg_error_o;
                bus.reg_valid_i = 1'b0;
            end
            if (bus.psel_o === 1'b1 && bus.penable_o === 1'b1) begin
                bus.pready_i  = (acc == waits);
                bus.prdata_i  = (acc == waits) ? rd : $urandom;
                bus.pslverr_i = (acc == waits) ? se : 1'($urandom_range(0, 1));
                acc++;
            end else begin
                bus.pready_i  = 1'b0;
                bus.prdata_i  = $urandom;
                bus.pslverr_i = 1'b0;
            end
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s response: no reg_ready_o within %0d cycles, expected at %0d", name, c, exp_lat);
        end
        checks++;
        if (c !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, c, exp_lat);
        end
        checks++;
        if (got_rd !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata: got %h, expected %h", name, got_rd, exp_rd);
        end
        checks++;
        if (got_err !== exp_err) begin
            errors++;
            $display("FAIL %s error: got %b, expected %b", name, got_err, exp_err);
        end
        checks++;
        if (acc !== exp_acc) begin
            errors++;
            $display("FAIL %s access_cycles: got %0d, expected %0d", name, acc, exp_acc);
        end
        checks++;
        if (!stable_ok || !phase_ok) begin
            errors++;
            $display("FAIL %s apb_phases: stable=%0d phase=%0d, expected 1 1", name, stable_ok, phase_ok);
        end

        // Cycle after the pulse: back in IDLE with everything quiet.
        @(posedge clk);
        #1;
        checks++;
        if ({bus.reg_ready_o, bus.reg_error_o, bus.reg_rdata_o, bus.psel_o, bus.penable_o,
             bus.paddr_o, bus.pwdata_o, bus.pwrite_o} !== '0) begin
            errors++;
            $display("FAIL %s idle_after: ready=%b err=%b rdata=%h psel=%b paddr=%h, expected all 0",
                     name, bus.reg_ready_o, bus.reg_error_o, bus.reg_rdata_o, bus.psel_o, bus.paddr_o);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.reg_valid_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.reg_ready_o, bus.reg_error_o, bus.reg_rdata_o, bus.psel_o, bus.penable_o,
             bus.paddr_o, bus.pwdata_o, bus.pwrite_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b psel=%b penable=%b rdata=%h, expected all 0",
                     bus.reg_ready_o, bus.psel_o, bus.penable_o, bus.reg_rdata_o);
        end
        bus.reg_valid_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_basic;
        run_txn("read_basic", 1'b0, 32'h1A10_0004, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    task automatic test_write_waits;
        run_txn("write_waits", 1'b1, 32'h1A10_0008, 32'h5, 4'hF, 2, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_strobe_error;
        run_txn("strobe_error", 1'b1, 32'h1A10_000C, 32'hCAFE_0001, 4'h3, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_slverr;
        run_txn("slverr_read", 1'b0, 32'h1A10_0010, 32'h0, 4'hF, 0, 32'h0000_1234, 1'b1, 1'b0);
    endtask

    task automatic test_timeout;
        run_txn("timeout", 1'b0, 32'h1A10_0014, 32'h0, 4'hF, 1000, 32'h0, 1'b0, 1'b0);
        run_txn("after_timeout", 1'b0, 32'h1A10_0018, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
        // pready on the very cycle the wait limit is reached: completion wins
        run_txn("threshold_ready", 1'b0, 32'h1A10_001C, 32'h0, 4'hF, int'(TO) - 1, 32'h7777_0001, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_txn("b2b_0", 1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b1, 1'b0);
        run_txn("b2b_1", 1'b0, 32'h0000_0103, 32'h0, 4'hF, 0, 32'h3333_4444, 1'b0, 1'b0);
    endtask

    task automatic test_valid_drop;
        run_txn("valid_drop", 1'b0, 32'h0000_0200, 32'h0, 4'hF, 3, 32'h5555_AAAA, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        bit quiet = 1;
        bus.reg_valid_i = 1'b1;
        bus.reg_write_i = 1'b0;
        bus.reg_addr_i  = 32'h1A10_0020;
        bus.pready_i    = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.psel_o !== 1'b0 || bus.penable_o !== 1'b0 || bus.reg_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: psel=%b penable=%b ready=%b, expected 0 0 0",
                     bus.psel_o, bus.penable_o, bus.reg_ready_o);
        end
        bus.reg_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus.reg_ready_o !== 1'b0 || bus.psel_o !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_mid_quiet: response or APB activity seen after release, expected none");
        end
        run_txn("after_reset", 1'b0, 32'h1A10_0024, 32'h0, 4'hF, 0, 32'h600D_0001, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            logic        wr    = 1'($urandom_range(0, 1));
            logic [3:0]  strb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            int          sel   = int'($urandom_range(0, 9));
            int          waits = (sel <= 5) ? sel : (sel == 6) ? int'(TO) - 1 : (sel == 7) ? int'(TO) : 0;
            logic        drop  = ($urandom_range(0, 4) == 0);
            run_txn($sformatf("rand_%0d", n), wr, $urandom, $urandom, strb, waits, $urandom,
                    1'($urandom_range(0, 1)), drop);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_waits();
        test_strobe_error();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_valid_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
